// File: rtl/regfile_sb.sv
// Two-read / one-write register file with write-through forwarding
// and a per-register busy scoreboard for the hazard unit.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             iss,
  input  logic [AW-1:0]    iss_dst,
  input  logic             flush,
  output logic             busy1,
  output logic             busy2,
  output logic [AW:0]      busy_cnt
);

  localparam int N = 2**AW;

  logic [WIDTH-1:0] rf [N];
  logic [N-1:0]     busy;
  logic [N-1:0]     busy_nx;
  logic [AW:0]      cnt_nx;
  logic             fwd1;
  logic             fwd2;

  // A new issue outranks a same-edge writeback: the new writer is pending.
  always_comb begin
    busy_nx = '0;
    for (int i = 1; i < N; i++) begin
      busy_nx[i] = !flush &&
        ((iss && iss_dst == AW'(i)) ||
         (busy[i] && !(we && wa == AW'(i))));
    end
  end

  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nx = cnt_nx + (AW+1)'(busy_nx[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rf[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (we && wa != '0) begin
        rf[wa] <= wd;
      end
      busy     <= busy_nx;
      busy_cnt <= cnt_nx;
    end
  end

  assign fwd1 = (BYPASS != 0) && we && (wa == ra1);
  assign fwd2 = (BYPASS != 0) && we && (wa == ra2);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!reset && ra1 != '0) begin
      rd1 = fwd1 ? wd : rf[ra1];
    end
    if (!reset && ra2 != '0) begin
      rd2 = fwd2 ? wd : rf[ra2];
    end
  end

  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, iss, flush;
  logic [4:0]  wa, ra1, ra2, iss_dst;
  logic [31:0] wd;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, busy1_b, busy2_b;
  logic [5:0]  cnt_a, cnt_b;

  logic        s_we, s_iss, s_flush;
  logic [2:0]  s_wa, s_ra1, s_ra2, s_dst;
  logic [15:0] s_wd;
  logic [15:0] s_rd1, s_rd2;
  logic        s_b1, s_b2;
  logic [3:0]  s_cnt;

  int total  = 0;
  int passed = 0;

  logic [31:0] m_rf [32];
  bit          m_bsy [32];
  logic [15:0] s_rf [8];
  bit          s_bsy [8];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .iss(iss), .iss_dst(iss_dst), .flush(flush),
    .busy1(busy1_a), .busy2(busy2_a), .busy_cnt(cnt_a)
  );

  regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .iss(iss), .iss_dst(iss_dst), .flush(flush),
    .busy1(busy1_b), .busy2(busy2_b), .busy_cnt(cnt_b)
  );

  regfile_sb #(.WIDTH(16), .AW(3), .BYPASS(1)) u_s (
    .clk(clk), .reset(reset), .we(s_we), .wa(s_wa), .wd(s_wd),
    .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .iss(s_iss), .iss_dst(s_dst), .flush(s_flush),
    .busy1(s_b1), .busy2(s_b2), .busy_cnt(s_cnt)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_bsy[i]);
    return c;
  endfunction

  task automatic idle();
    we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
    iss = 0; iss_dst = 0; flush = 0;
    s_we = 0; s_wa = 0; s_wd = 0; s_ra1 = 0; s_ra2 = 0;
    s_iss = 0; s_dst = 0; s_flush = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_bsy[i] = 0; end
    for (int i = 0; i < 8; i++) begin s_rf[i] = 0; s_bsy[i] = 0; end
  endtask

  // Rules applied in rising priority so the last assignment wins.
  task automatic apply_edge();
    @(posedge clk);
    if (we && wa != 0) m_rf[wa] = wd;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_bsy[i] = 0;
    end else begin
      if (we) m_bsy[wa] = 0;
      if (iss && iss_dst != 0) m_bsy[iss_dst] = 1;
    end
    if (s_we && s_wa != 0) s_rf[s_wa] = s_wd;
    if (s_flush) begin
      for (int i = 0; i < 8; i++) s_bsy[i] = 0;
    end else begin
      if (s_we) s_bsy[s_wa] = 0;
      if (s_iss && s_dst != 0) s_bsy[s_dst] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    reset = 1;
    ra1 = 5; ra2 = 7;
    #1;
    total++;
    if (rd1_a !== 32'h0) $display("FAIL reset_rd1 got %h want 0", rd1_a);
    else passed++;
    total++;
    if (busy2_a !== 1'b0) $display("FAIL reset_busy2 got %b want 0", busy2_a);
    else passed++;
    total++;
    if (cnt_a !== 6'd0) $display("FAIL reset_cnt got %0d want 0", cnt_a);
    else passed++;
    total++;
    if (s_cnt !== 4'd0) $display("FAIL reset_scnt got %0d want 0", s_cnt);
    else passed++;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    we = 1; wa = 5; wd = 32'hDEADBEEF; iss = 1; iss_dst = 7;
    apply_edge();
    @(negedge clk);
    idle();
    ra1 = 5; ra2 = 7;
    #1;
    total++;
    if (rd1_a !== 32'hDEADBEEF || busy2_a !== 1'b1 || cnt_a !== 6'd1)
      $display("FAIL mid_setup got %h/%b/%0d want deadbeef/1/1",
               rd1_a, busy2_a, cnt_a);
    else passed++;
    #2;
    reset = 1;
    #1;
    total++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h0)
      $display("FAIL mid_rd got %h/%h want 0", rd1_a, rd1_b);
    else passed++;
    total++;
    if (busy2_a !== 1'b0 || cnt_a !== 6'd0)
      $display("FAIL mid_busy got %b/%0d want 0/0", busy2_a, cnt_a);
    else passed++;
    model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    we = 1; wa = 3; wd = 32'h12345678; ra1 = 3;
    #1;
    total++;
    if (rd1_a !== 32'h12345678)
      $display("FAIL byp1_same got %h want 12345678", rd1_a);
    else passed++;
    total++;
    if (rd1_b !== 32'h0)
      $display("FAIL byp0_same got %h want 0", rd1_b);
    else passed++;
    apply_edge();
    total++;
    if (rd1_b !== 32'h12345678)
      $display("FAIL byp0_after got %h want 12345678", rd1_b);
    else passed++;
  endtask

  task automatic test_reg0();
    @(negedge clk);
    idle();
    we = 1; wa = 0; wd = 32'hFFFFFFFF; iss = 1; iss_dst = 0;
    #1;
    total++;
    if (rd1_a !== 0 || rd2_a !== 0 || busy1_a !== 0)
      $display("FAIL r0_same got %h/%h/%b want 0", rd1_a, rd2_a, busy1_a);
    else passed++;
    apply_edge();
    total++;
    if (rd1_a !== 0 || rd2_a !== 0 || busy1_a !== 0 || cnt_a !== 0)
      $display("FAIL r0_after got %h/%h/%b/%0d want 0",
               rd1_a, rd2_a, busy1_a, cnt_a);
    else passed++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    iss = 1; iss_dst = 9;
    apply_edge();
    @(negedge clk);
    idle();
    ra1 = 9;
    #1;
    total++;
    if (busy1_a !== 1'b1 || cnt_a !== 6'd1)
      $display("FAIL sb_set got %b/%0d want 1/1", busy1_a, cnt_a);
    else passed++;
    we = 1; wa = 9; wd = 32'h0BADC0DE;
    #1;
    total++;
    if (busy1_a !== 1'b1)
      $display("FAIL sb_noclr_before got %b want 1", busy1_a);
    else passed++;
    apply_edge();
    total++;
    if (busy1_a !== 1'b0 || cnt_a !== 6'd0)
      $display("FAIL sb_clr got %b/%0d want 0/0", busy1_a, cnt_a);
    else passed++;
  endtask

  task automatic test_simul();
    @(negedge clk);
    idle();
    iss = 1; iss_dst = 9; we = 1; wa = 9; wd = 32'hCAFEF00D;
    apply_edge();
    @(negedge clk);
    idle();
    ra1 = 9; ra2 = 9;
    #1;
    total++;
    if (busy1_a !== 1'b1 || rd1_a !== 32'hCAFEF00D || rd2_a !== rd1_a)
      $display("FAIL simul_iss_wb got %b/%h/%h want 1/cafef00d",
               busy1_a, rd1_a, rd2_a);
    else passed++;
    flush = 1; iss = 1; iss_dst = 4; ra2 = 4;
    apply_edge();
    total++;
    if (cnt_a !== 6'd0 || busy2_a !== 1'b0 || busy1_a !== 1'b0)
      $display("FAIL simul_flush got %0d/%b want 0/0", cnt_a, busy2_a);
    else passed++;
  endtask

  task automatic test_param();
    for (int r = 1; r < 8; r++) begin
      @(negedge clk);
      idle();
      s_iss = 1; s_dst = 3'(r);
      apply_edge();
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (s_cnt !== 4'd7) $display("FAIL p_cnt7 got %0d want 7", s_cnt);
    else passed++;
    s_we = 1; s_wa = 7; s_wd = 16'hA5A5; s_ra1 = 7;
    #1;
    total++;
    if (s_rd1 !== 16'hA5A5) $display("FAIL p_byp got %h want a5a5", s_rd1);
    else passed++;
    apply_edge();
    total++;
    if (s_rd1 !== 16'hA5A5 || s_cnt !== 4'd6)
      $display("FAIL p_after got %h/%0d want a5a5/6", s_rd1, s_cnt);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] e1a, e2a, e1b;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      idle();
      we      = ($urandom_range(0, 1) == 1);
      wa      = 5'($urandom_range(0, n[0] ? 7 : 31));
      wd      = $urandom;
      iss     = ($urandom_range(0, 2) != 0);
      iss_dst = 5'($urandom_range(0, n[1] ? 7 : 31));
      ra1     = 5'($urandom_range(0, 7));
      ra2     = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      flush   = ($urandom_range(0, 15) == 0);
      #1;
      e1a = exp_rd(ra1, 1);
      e2a = exp_rd(ra2, 1);
      e1b = exp_rd(ra1, 0);
      total++;
      if (rd1_a !== e1a || rd2_a !== e2a || rd1_b !== e1b)
        $display("FAIL rnd_rd n=%0d got %h/%h/%h want %h/%h/%h",
                 n, rd1_a, rd2_a, rd1_b, e1a, e2a, e1b);
      else passed++;
      total++;
      if (busy1_a !== m_bsy[ra1] || busy2_a !== m_bsy[ra2] ||
          busy1_b !== m_bsy[ra1])
        $display("FAIL rnd_busy n=%0d got %b%b want %b%b",
                 n, busy1_a, busy2_a, m_bsy[ra1], m_bsy[ra2]);
      else passed++;
      apply_edge();
      total++;
      if (cnt_a !== 6'(exp_cnt()) || cnt_b !== 6'(exp_cnt()))
        $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d",
                 n, cnt_a, cnt_b, exp_cnt());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_bypass();
    test_reg0();
    test_scoreboard();
    test_simul();
    test_param();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
